// File: rtl/field_merge_scheduler_if.sv
// Stream bundle between the two encoder output FIFOs, the merge scheduler and the output FIFO.
// master = scheduler side (pops sources, pushes output); slave = FIFO side.
interface field_merge_scheduler_if #(
    parameter int IDX_W = 10
);
    logic             v_empty;
    logic [7:0]       v_data;
    logic [IDX_W-1:0] v_index;
    logic             v_last;
    logic             v_pop;

    logic             r_empty;
    logic [7:0]       r_data;
    logic [IDX_W-1:0] r_index;
    logic             r_last;
    logic             r_pop;

    logic             out_full;
    logic             out_push;
    logic [7:0]       out_data;

    modport master (
        input  v_empty, v_data, v_index, v_last,
        output v_pop,
        input  r_empty, r_data, r_index, r_last,
        output r_pop,
        input  out_full,
        output out_push, out_data
    );

    modport slave (
        output v_empty, v_data, v_index, v_last,
        input  v_pop,
        output r_empty, r_data, r_index, r_last,
        input  r_pop,
        output out_full,
        input  out_push, out_data
    );
endinterface

// File: rtl/field_merge_scheduler.sv
// Merges varint and raw-data field streams into one byte FIFO in ascending field-index order.
// Optional FIELD_MERGE_TIMEOUT_EN adds a stall timer that skips a missing field index.
//
// state | meaning
// SEL   | waiting for a source head whose index equals next_index
// GNT_V | copying the current varint field, byte per cycle
// GNT_R | copying the current raw-data field, byte per cycle
module field_merge_scheduler #(
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock_clk,
    input  logic                    reset_reset_n,
    input  logic                    clr,
    field_merge_scheduler_if.master bus,
    output logic [IDX_W-1:0]        next_index,
    output logic                    busy,
    output logic [CNT_W-1:0]        byte_count,
    output logic                    dup_err
`ifdef FIELD_MERGE_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    typedef enum logic [1:0] {
        SEL   = 2'd0,
        GNT_V = 2'd1,
        GNT_R = 2'd2
    } state_t;

    state_t state;
    logic   go;
    logic   vm;
    logic   rm;
    logic   v_xfer;
    logic   r_xfer;
    logic   xfer;
    logic   xfer_last;

    // Nothing moves while reset or clear is asserted, so a clear mid-field drops it cleanly.
    assign go        = reset_reset_n & ~clr;
    assign vm        = ~bus.v_empty & (bus.v_index == next_index);
    assign rm        = ~bus.r_empty & (bus.r_index == next_index);
    assign v_xfer    = go & (state == GNT_V) & ~bus.v_empty & ~bus.out_full;
    assign r_xfer    = go & (state == GNT_R) & ~bus.r_empty & ~bus.out_full;
    assign xfer      = v_xfer | r_xfer;
    assign xfer_last = (v_xfer & bus.v_last) | (r_xfer & bus.r_last);

    assign bus.v_pop    = v_xfer;
    assign bus.r_pop    = r_xfer;
    assign bus.out_push = xfer;
    assign bus.out_data = v_xfer ? bus.v_data : (r_xfer ? bus.r_data : 8'h00);
    assign busy         = reset_reset_n & (state != SEL);

`ifdef FIELD_MERGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] STALL_RELOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0]    stall_cnt;
    logic             stalled;
    logic [IDX_W-1:0] min_index;

    assign stalled = (state == SEL) & ~vm & ~rm & (~bus.v_empty | ~bus.r_empty);

    always_comb begin
        min_index = bus.v_index;
        if (bus.v_empty)
            min_index = bus.r_index;
        else if (~bus.r_empty && (bus.r_index < bus.v_index))
            min_index = bus.r_index;
    end
`endif

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n || clr) begin
            state      <= SEL;
            next_index <= '0;
            byte_count <= '0;
            dup_err    <= 1'b0;
`ifdef FIELD_MERGE_TIMEOUT_EN
            stall_cnt   <= STALL_RELOAD;
            timeout_err <= 1'b0;
`endif
        end else begin
            if (xfer)
                byte_count <= byte_count + CNT_W'(1);
            case (state)
                SEL: begin
                    if (vm) begin
                        state <= GNT_V;
                        if (rm)
                            dup_err <= 1'b1;
                    end else if (rm) begin
                        state <= GNT_R;
                    end
                end
                GNT_V, GNT_R: begin
                    if (xfer_last) begin
                        next_index <= next_index + IDX_W'(1);
                        state      <= SEL;
                    end
                end
                default: state <= SEL;
            endcase
`ifdef FIELD_MERGE_TIMEOUT_EN
            // Down-counter: terminal count on the TIMEOUT-th consecutive stall cycle.
            if ((state == SEL) && (vm || rm)) begin
                stall_cnt <= STALL_RELOAD;
            end else if (stalled) begin
                if (stall_cnt == '0) begin
                    next_index  <= min_index;
                    timeout_err <= 1'b1;
                    stall_cnt   <= STALL_RELOAD;
                end else begin
                    stall_cnt <= stall_cnt - TW'(1);
                end
            end
`endif
        end
    end

endmodule
